// File: rtl/stream_arb_mux_if.sv
// Stream merge bundle: N input streams plus one output stream.
// Channel count is 2**sel_bits; data is a packed per-channel matrix.
interface stream_arb_mux_if #(
    parameter int data_bits = 8,
    parameter int sel_bits  = 2
);
    localparam int N = 2 ** sel_bits;

    logic [N-1:0]                in_valid;
    logic [N-1:0]                in_ready;
    logic [N-1:0][data_bits-1:0] in_data;
    logic [N-1:0]                in_last;
    logic [N-1:0]                ch_enable;
    logic                        out_valid;
    logic                        out_ready;
    logic [data_bits-1:0]        out_data;
    logic [sel_bits-1:0]         out_sel;
    logic                        out_last;

    // Producer/consumer side that drives the inputs and sinks the output
    modport master (
        output in_valid, in_data, in_last, ch_enable, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data, in_last, ch_enable, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/stream_arb_mux.sv
// N:1 stream merge with round-robin or fixed-priority arbitration,
// optional packet lock, and a single registered output stage.
module stream_arb_mux #(
    parameter int data_bits = 8,
    parameter int sel_bits  = 2,
    parameter int rr_mode   = 1,
    parameter int pkt_mode  = 0
) (
    input logic             clk,
    input logic             rst_n,
    stream_arb_mux_if.slave s
);
    localparam int N = 2 ** sel_bits;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]          state;
    logic [sel_bits-1:0] ptr;
    logic [sel_bits-1:0] lock_ch;
    logic [sel_bits-1:0] gidx;
    logic                gany;
    logic [N-1:0]        req;
    logic [N-1:0]        grant;
    logic                load;
    logic                xfer;
    logic                glast;

    // Pick one channel: locked owner, else first request from ptr or lowest
    always_comb begin
        req  = s.in_valid & s.ch_enable;
        gany = 1'b0;
        gidx = '0;
        if (pkt_mode != 0 && state == LOCKED) begin
            gany = 1'b1;
            gidx = lock_ch;
        end else if (rr_mode != 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[ptr + sel_bits'(k)]) begin
                    gany = 1'b1;
                    gidx = ptr + sel_bits'(k);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[k]) begin
                    gany = 1'b1;
                    gidx = sel_bits'(k);
                end
            end
        end
        grant = '0;
        if (gany) grant[gidx] = 1'b1;
    end

    // Ready only to the granted channel, only when the output can load
    always_comb begin
        load       = !s.out_valid || s.out_ready;
        s.in_ready = {N{load & rst_n}} & grant;
        xfer       = |(s.in_valid & s.in_ready);
        glast      = s.in_last[gidx];
    end

    // Output register stage; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_sel   <= '0;
            s.out_last  <= 1'b0;
        end else if (load) begin
            s.out_valid <= xfer;
            if (xfer) begin
                s.out_data <= s.in_data[gidx];
                s.out_sel  <= gidx;
                s.out_last <= glast & (pkt_mode != 0);
            end
        end
    end

    // Round-robin pointer moves past the winner (at packet end if locking)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && (pkt_mode == 0 || glast)) begin
            ptr <= gidx + sel_bits'(1);
        end
    end

    // Packet lock: hold the grant from first beat through the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else if (pkt_mode != 0 && xfer) begin
            case (state)
                IDLE: begin
                    if (!glast) begin
                        state   <= LOCKED;
                        lock_ch <= gidx;
                    end
                end
                LOCKED: begin
                    if (glast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
